// File: rtl/cache_controller.sv
// cache_controller
// Miss-handling sequencer for a 2-way write-back data cache.
// On a CPU miss it stalls the pipeline and writes back a dirty victim over
// the memory request/ready port. It then fetches the missing block and
// issues a one-cycle fill/commit so the cache installs the line and
// completes the access. Saturating hit/miss counters are also kept.
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   cpu_rd_en/cpu_wr_en/cpu_addr CPU request (store wins over load)
//   cache_hit                    combinational hit for cache_addr
//   victim_dirty/addr/data       replacement-way state from the cache
//   cache_addr/rd_en/wr_en       cache access controls
//   fetch_enable/fetch_data      one-cycle fill strobe and block
//   stall                        pipeline freeze
//   mem_req/we/addr/wdata        memory block request
//   mem_ready/mem_rdata          memory completion and read block
//   hit_count/miss_count         saturating performance counters
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | serve CPU hits, detect and latch misses
// WRITEBACK | write dirty victim block to memory
// FETCH     | read missing block from memory
// FILL      | one-cycle install of the block and CPU replay
module cache_controller #(
   parameter int DATA_WIDTH  = 32,
   parameter int BLOCK_SIZE  = 4,
   parameter int OFFSET_BITS = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             cpu_rd_en,
   input  logic                             cpu_wr_en,
   input  logic [DATA_WIDTH-1:0]            cpu_addr,
   input  logic                             cache_hit,
   input  logic                             victim_dirty,
   input  logic [DATA_WIDTH-1:0]            victim_addr,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] victim_data,
   output logic [DATA_WIDTH-1:0]            cache_addr,
   output logic                             cache_rd_en,
   output logic                             cache_wr_en,
   output logic                             fetch_enable,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] fetch_data,
   output logic                             stall,
   output logic                             mem_req,
   output logic                             mem_we,
   output logic [DATA_WIDTH-1:0]            mem_addr,
   output logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_wdata,
   input  logic                             mem_ready,
   input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0]            hit_count,
   output logic [DATA_WIDTH-1:0]            miss_count
);

   localparam int BW = BLOCK_SIZE*DATA_WIDTH;
   localparam logic [DATA_WIDTH-1:0] BLK_MASK = ~((DATA_WIDTH'(1) << OFFSET_BITS) - DATA_WIDTH'(1));
   localparam logic [DATA_WIDTH-1:0] CNT_MAX  = '1;

   typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, FILL} state_t;

   state_t                state_q, state_d;
   logic                  op_wr_q, op_wr_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] vaddr_q, vaddr_d;
   logic [BW-1:0]         vdata_q, vdata_d;
   logic [BW-1:0]         fill_q, fill_d;
   logic [DATA_WIDTH-1:0] hit_q, hit_d;
   logic [DATA_WIDTH-1:0] miss_q, miss_d;

   logic op_any;
   assign op_any = cpu_wr_en | cpu_rd_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_wr_q <= 1'b0;
         addr_q  <= '0;
         vaddr_q <= '0;
         vdata_q <= '0;
         fill_q  <= '0;
         hit_q   <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         op_wr_q <= op_wr_d;
         addr_q  <= addr_d;
         vaddr_q <= vaddr_d;
         vdata_q <= vdata_d;
         fill_q  <= fill_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      op_wr_d      = op_wr_q;
      addr_d       = addr_q;
      vaddr_d      = vaddr_q;
      vdata_d      = vdata_q;
      fill_d       = fill_q;
      hit_d        = hit_q;
      miss_d       = miss_q;
      cache_addr   = '0;
      cache_rd_en  = 1'b0;
      cache_wr_en  = 1'b0;
      fetch_enable = 1'b0;
      stall        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;

      unique case (state_q)
         IDLE: begin
            cache_addr  = cpu_addr;
            cache_wr_en = cpu_wr_en;
            cache_rd_en = cpu_rd_en & ~cpu_wr_en;
            stall       = op_any & ~cache_hit;
            if (op_any) begin
               if (cache_hit) begin
                  if (hit_q != CNT_MAX) hit_d = hit_q + DATA_WIDTH'(1);
               end else begin
                  if (miss_q != CNT_MAX) miss_d = miss_q + DATA_WIDTH'(1);
                  op_wr_d = cpu_wr_en;
                  addr_d  = cpu_addr;
                  vaddr_d = victim_addr;
                  vdata_d = victim_data;
                  state_d = victim_dirty ? WRITEBACK : FETCH;
               end
            end
         end
         WRITEBACK: begin
            stall     = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = vaddr_q;
            mem_wdata = vdata_q;
            if (mem_ready) state_d = FETCH;
         end
         FETCH: begin
            stall    = 1'b1;
            mem_req  = 1'b1;
            mem_addr = addr_q & BLK_MASK;
            if (mem_ready) begin
               fill_d  = mem_rdata;
               state_d = FILL;
            end
         end
         FILL: begin
            fetch_enable = 1'b1;
            cache_addr   = addr_q;
            cache_wr_en  = op_wr_q;
            cache_rd_en  = ~op_wr_q;
            state_d      = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign fetch_data = fill_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_controller.sv
module tb_cache_controller;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         cpu_rd_en, cpu_wr_en;
   logic [31:0]  cpu_addr;
   logic         cache_hit, victim_dirty;
   logic [31:0]  victim_addr;
   logic [127:0] victim_data;
   logic [31:0]  cache_addr;
   logic         cache_rd_en, cache_wr_en, fetch_enable;
   logic [127:0] fetch_data;
   logic         stall, mem_req, mem_we;
   logic [31:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ready;
   logic [127:0] mem_rdata;
   logic [31:0]  hit_count, miss_count;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [127:0] RDATA = {32'd4, 32'd3, 32'd2, 32'd1};
   localparam logic [127:0] VDATA = {4{32'hAAAA_AAAA}};

   always #5 clk = ~clk;

   cache_controller dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en), .cpu_addr(cpu_addr),
      .cache_hit(cache_hit), .victim_dirty(victim_dirty),
      .victim_addr(victim_addr), .victim_data(victim_data),
      .cache_addr(cache_addr), .cache_rd_en(cache_rd_en), .cache_wr_en(cache_wr_en),
      .fetch_enable(fetch_enable), .fetch_data(fetch_data), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   typedef struct {
      logic        rd, wr;
      logic [31:0] addr;
      logic        hit, dirty, rdy;
      logic        stall, crd, cwr, fe, req, we;
      logic [31:0] caddr, maddr;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic hit, input logic dirty, input logic rdy);
      cpu_rd_en    = rd;
      cpu_wr_en    = wr;
      cpu_addr     = addr;
      cache_hit    = hit;
      victim_dirty = dirty;
      mem_ready    = rdy;
   endtask

   // Advance one clock; inputs are changed and outputs sampled around the negedge.
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      victim_addr = 32'h800;
      victim_data = VDATA;
      mem_rdata   = RDATA;
      drive(0, 0, 32'h0, 0, 0, 0);
      tick(); tick();
      #1;
      chk("reset_stall", stall, 0);
      chk("reset_req", mem_req, 0);
      chk("reset_hits", hit_count, 0);
      chk("reset_miss", miss_count, 0);
      chk("reset_fill", fetch_data, 0);
      rst_n = 1'b1;

      //          rd wr addr     hit d rdy  stall crd cwr fe req we caddr    maddr
      vecs[0] = '{1, 0, 32'h100, 1, 0, 0,   0,    1,  0,  0, 0,  0, 32'h100, 32'h0};
      vecs[1] = '{0, 1, 32'h104, 1, 0, 0,   0,    0,  1,  0, 0,  0, 32'h104, 32'h0};
      vecs[2] = '{0, 0, 32'h108, 0, 0, 0,   0,    0,  0,  0, 0,  0, 32'h108, 32'h0};
      vecs[3] = '{1, 0, 32'h234, 0, 0, 0,   1,    1,  0,  0, 0,  0, 32'h234, 32'h0};
      vecs[4] = '{1, 0, 32'h234, 0, 0, 0,   1,    0,  0,  0, 1,  0, 32'h0,   32'h230};
      vecs[5] = '{0, 0, 32'h999, 0, 0, 0,   1,    0,  0,  0, 1,  0, 32'h0,   32'h230};
      vecs[6] = '{0, 0, 32'h999, 0, 0, 1,   1,    0,  0,  0, 1,  0, 32'h0,   32'h230};
      vecs[7] = '{0, 0, 32'h999, 0, 0, 0,   0,    1,  0,  1, 0,  0, 32'h234, 32'h0};
      vecs[8] = '{0, 0, 32'h999, 0, 0, 1,   0,    0,  0,  0, 0,  0, 32'h999, 32'h0};
      vecs[9] = '{0, 0, 32'h99C, 0, 0, 0,   0,    0,  0,  0, 0,  0, 32'h99C, 32'h0};

      for (int i = 0; i < 10; i++) begin
         tick();
         drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].hit, vecs[i].dirty, vecs[i].rdy);
         #1;
         chk($sformatf("v%0d_stall", i), stall, vecs[i].stall);
         chk($sformatf("v%0d_crd", i), cache_rd_en, vecs[i].crd);
         chk($sformatf("v%0d_cwr", i), cache_wr_en, vecs[i].cwr);
         chk($sformatf("v%0d_fe", i), fetch_enable, vecs[i].fe);
         chk($sformatf("v%0d_req", i), mem_req, vecs[i].req);
         chk($sformatf("v%0d_we", i), mem_we, vecs[i].we);
         chk($sformatf("v%0d_caddr", i), cache_addr, vecs[i].caddr);
         chk($sformatf("v%0d_maddr", i), mem_addr, vecs[i].maddr);
         if (vecs[i].fe) chk($sformatf("v%0d_fdata", i), fetch_data, RDATA);
      end
      tick(); #1;
      chk("table_hits", hit_count, 2);
      chk("table_miss", miss_count, 1);

      // Dirty write miss: victim written back, later victim input changes are ignored.
      drive(0, 1, 32'h10, 0, 1, 0);
      #1;
      chk("dw_idle_stall", stall, 1);
      tick();
      drive(0, 0, 32'h500, 0, 0, 0);
      victim_addr = 32'h900;
      victim_data = {4{32'h5555_5555}};
      #1;
      chk("dw_wb_req", mem_req, 1);
      chk("dw_wb_we", mem_we, 1);
      chk("dw_wb_addr", mem_addr, 32'h800);
      chk("dw_wb_data", mem_wdata, VDATA);
      chk("dw_wb_cen", {cache_rd_en, cache_wr_en}, 0);
      tick();
      #1;
      chk("dw_wb_hold_addr", mem_addr, 32'h800);
      chk("dw_wb_hold_we", mem_we, 1);
      mem_ready = 1'b1;
      tick();
      #1;
      chk("dw_fetch_we", mem_we, 0);
      chk("dw_fetch_addr", mem_addr, 32'h10);
      chk("dw_fetch_stall", stall, 1);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("dw_fill_fe", fetch_enable, 1);
      chk("dw_fill_cwr", cache_wr_en, 1);
      chk("dw_fill_crd", cache_rd_en, 0);
      chk("dw_fill_caddr", cache_addr, 32'h10);
      chk("dw_fill_stall", stall, 0);
      tick(); #1;
      chk("dw_miss", miss_count, 2);

      // Both rd and wr on a clean miss: treated as a write.
      drive(1, 1, 32'h44, 0, 0, 0);
      #1;
      chk("rw_idle_cwr", cache_wr_en, 1);
      chk("rw_idle_crd", cache_rd_en, 0);
      tick();
      drive(0, 0, 32'h0, 0, 0, 1);
      #1;
      chk("rw_fetch_addr", mem_addr, 32'h40);
      tick();
      mem_ready = 1'b0;
      #1;
      chk("rw_fill_cwr", cache_wr_en, 1);
      chk("rw_fill_crd", cache_rd_en, 0);
      tick(); #1;
      chk("rw_miss", miss_count, 3);

      // Reset during FETCH abandons the request.
      drive(1, 0, 32'h234, 0, 0, 0);
      tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      #1;
      chk("rst_pre_req", mem_req, 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_req", mem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_hits", hit_count, 0);
      chk("rst_miss", miss_count, 0);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #1;
      chk("rst_rdy_idle_req", mem_req, 0);
      chk("rst_rdy_idle_fe", fetch_enable, 0);
      chk("rst_fill_zero", fetch_data, 0);

      // Saturation: preload hit counter, then hit.
      dut.hit_q = 32'hFFFF_FFFF;
      drive(1, 0, 32'h100, 1, 0, 0);
      tick();
      drive(0, 0, 32'h0, 0, 0, 0);
      #1;
      chk("sat_hits", hit_count, 32'hFFFF_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
